ram_arbiter: RTL and testbench

Sequential arbiter that shares the single-port 16-bit-address / 64-bit-data program/data RAM between three requesters: the CPU core (0), the program loader (1) and a host/debug port (2). It sits between the requesters and the RAM's address/data/write-size inputs. It serialises accesses with a req/ack handshake, picks round-robin, and supports bounded locked tenures so that multi-word sequences (stack pushes, loader bursts) run atomically.

---
 rtl/ram_arbiter_pkg.sv | 30 +++
 rtl/ram_arbiter_rr_pick.sv | 27 ++
 rtl/ram_arbiter.sv | 169 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared encodings for the RAM arbiter: FSM states, write-size codes, helpers.
package ram_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_HOLD  = 2'd3
  } arb_state_t;

  // Write-size codes, same encoding as the RAM's wr input
  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_B1   = 2'b01;
  localparam logic [1:0] SZ_B4   = 2'b10;
  localparam logic [1:0] SZ_B8   = 2'b11;

  // Requester index width (three requesters need two bits)
  localparam int IDX_W = 2;

  // One-hot (3 requesters) to binary index; zero input maps to 0
  function automatic logic [IDX_W-1:0] oh2idx(input logic [2:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    if (oh[1]) idx = 2'd1;
    if (oh[2]) idx = 2'd2;
    return idx;
  endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Round-robin winner search: first requester with req high, starting at last+1 and wrapping.
module rr_pick
  import ram_arbiter_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  winner,
  output logic             valid
);

  // Scan distances 1..NREQ from last so that last itself is checked at the end
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!valid && req[j] && (((int'(last) + k) % NREQ) == j)) begin
          winner[j] = 1'b1;
          valid     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Three-way round-robin arbiter for the single-port program/data RAM,
// with req/ack handshake and bounded locked tenures for atomic sequences.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int AW       = 16,
  parameter int DW       = 64,
  parameter int LOCK_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      lock,
  input  logic [NREQ-1:0]      we,
  input  logic [2*NREQ-1:0]    size,
  input  logic [AW*NREQ-1:0]   addr,
  input  logic [DW*NREQ-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      ack,
  output logic [DW-1:0]        rdata,
  output logic [AW-1:0]        ram_addr,
  output logic                 ram_we,
  output logic [1:0]           ram_size,
  output logic [DW-1:0]        ram_wdata,
  input  logic [DW-1:0]        ram_rdata
);

  localparam int TW = $clog2(LOCK_MAX + 1);
  localparam logic [TW-1:0] TMAX = TW'(LOCK_MAX);

  arb_state_t       state, state_n;
  logic [NREQ-1:0]  gnt_n;
  logic [IDX_W-1:0] last, last_n;
  logic [TW-1:0]    tcnt, tcnt_n, tcnt_inc;

  logic             ld;
  logic [IDX_W-1:0] ld_idx;
  logic             we_clr;

  logic [NREQ-1:0]  pick_oh;
  logic             pick_vld;

  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_wdata;
  logic [1:0]       sel_size;
  logic             sel_we;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .last   (last),
    .winner (pick_oh),
    .valid  (pick_vld)
  );

  // Saturating tenure counter increment
  assign tcnt_inc = (tcnt == TMAX) ? TMAX : tcnt + 1'b1;

  // Ack and read data are only driven while waiting on the RAM; last always holds the owner
  assign ack   = (state == ARB_WAIT) ? gnt : '0;
  assign rdata = (state == ARB_WAIT) ? ram_rdata : '0;

  // Operand mux for the requester being latched
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_size  = SZ_NONE;
    sel_we    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDX_W'(i) == ld_idx) begin
        sel_addr  = addr[i*AW +: AW];
        sel_wdata = wdata[i*DW +: DW];
        sel_size  = size[i*2 +: 2];
        sel_we    = we[i];
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_n;
  end

  // Next-state, grant and tenure-count decisions
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    last_n  = last;
    tcnt_n  = tcnt;
    ld      = 1'b0;
    ld_idx  = last;
    we_clr  = 1'b0;
    case (state)
      ARB_IDLE: begin
        gnt_n = '0;
        if (pick_vld) begin
          ld      = 1'b1;
          ld_idx  = oh2idx(pick_oh);
          gnt_n   = pick_oh;
          last_n  = oh2idx(pick_oh);
          tcnt_n  = '0;
          state_n = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        tcnt_n  = tcnt_inc;
        we_clr  = 1'b1;
        state_n = ARB_WAIT;
      end
      ARB_WAIT: begin
        we_clr = 1'b1;
        if (lock[last] && (tcnt < TMAX)) begin
          state_n = ARB_HOLD;
        end else begin
          gnt_n   = '0;
          state_n = ARB_IDLE;
        end
      end
      ARB_HOLD: begin
        // Only the owner is looked at; everyone else waits for release
        if (req[last]) begin
          ld      = 1'b1;
          ld_idx  = last;
          state_n = ARB_ISSUE;
        end else if (!lock[last]) begin
          gnt_n   = '0;
          state_n = ARB_IDLE;
        end else begin
          tcnt_n = tcnt_inc;
          if (tcnt_inc == TMAX) begin
            gnt_n   = '0;
            state_n = ARB_IDLE;
          end
        end
      end
      default: begin
        gnt_n   = '0;
        state_n = ARB_IDLE;
      end
    endcase
  end

  // Grant, pointer, counter and registered RAM-side operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt       <= '0;
      last      <= IDX_W'(NREQ - 1);
      tcnt      <= '0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_size  <= SZ_NONE;
      ram_wdata <= '0;
    end else begin
      gnt  <= gnt_n;
      last <= last_n;
      tcnt <= tcnt_n;
      if (ld) begin
        ram_addr  <= sel_addr;
        ram_we    <= sel_we && (sel_size != SZ_NONE);
        ram_size  <= sel_size;
        ram_wdata <= sel_wdata;
      end else if (we_clr) begin
        ram_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a one-cycle-latency RAM model.
module tb_ram_arbiter;

  logic          clk;
  logic          rst;
  logic [2:0]    req, lock, we;
  logic [5:0]    size;
  logic [47:0]   addr;
  logic [191:0]  wdata;
  logic [2:0]    gnt, ack;
  logic [63:0]   rdata;
  logic [15:0]   ram_addr;
  logic          ram_we;
  logic [1:0]    ram_size;
  logic [63:0]   ram_wdata;
  logic [63:0]   ram_rdata;

  logic [63:0]   mem [0:1023];
  int            total = 0;
  int            bad   = 0;

  ram_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .lock      (lock),
    .we        (we),
    .size      (size),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .ack       (ack),
    .rdata     (rdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_size  (ram_size),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered read, full-word write
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[9:0]] <= ram_wdata;
    ram_rdata <= mem[ram_addr[9:0]];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic w, input logic [1:0] sz,
                        input logic [15:0] a, input logic [63:0] d);
    we[i]             = w;
    size[i*2 +: 2]    = sz;
    addr[i*16 +: 16]  = a;
    wdata[i*64 +: 64] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] exp_oh;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[16] = 64'hDEADBEEF_00000001;
    rst = 1'b1; req = '0; lock = '0; we = '0; size = '0; addr = '0; wdata = '0;
    step();
    step();
    // reset state
    chk("rst_gnt",   {61'd0, gnt}, 64'd0);
    chk("rst_ack",   {61'd0, ack}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_we",    {63'd0, ram_we}, 64'd0);
    chk("rst_addr",  {48'd0, ram_addr}, 64'd0);
    chk("rst_size",  {62'd0, ram_size}, 64'd0);
    chk("rst_wdata", ram_wdata, 64'd0);
    rst = 1'b0;

    // single unlocked read by core
    set_op(0, 1'b0, 2'b00, 16'h0010, 64'd0);
    req = 3'b001;
    chk("rd_c0_gnt", {61'd0, gnt}, 64'd0);
    step();
    chk("rd_c1_addr", {48'd0, ram_addr}, 64'h0010);
    chk("rd_c1_gnt",  {61'd0, gnt}, 64'd1);
    chk("rd_c1_ack",  {61'd0, ack}, 64'd0);
    step();
    chk("rd_c2_ack",   {61'd0, ack}, 64'd1);
    chk("rd_c2_rdata", rdata, 64'hDEADBEEF_00000001);
    req = 3'b000;
    step();
    chk("rd_c3_gnt", {61'd0, gnt}, 64'd0);
    chk("rd_c3_ack", {61'd0, ack}, 64'd0);

    // all three requesting: round robin 0,1,2,0
    do_reset();
    set_op(0, 1'b0, 2'b00, 16'h0000, 64'd0);
    set_op(1, 1'b0, 2'b00, 16'h0000, 64'd0);
    set_op(2, 1'b0, 2'b00, 16'h0000, 64'd0);
    req = 3'b111;
    for (int g = 0; g < 4; g++) begin
      exp_oh = 3'b001 << (g % 3);
      step();
      chk($sformatf("rr%0d_gnt", g), {61'd0, gnt}, {61'd0, exp_oh});
      chk($sformatf("rr%0d_ack_issue", g), {61'd0, ack}, 64'd0);
      step();
      chk($sformatf("rr%0d_ack", g), {61'd0, ack}, {61'd0, exp_oh});
      step();
      chk($sformatf("rr%0d_idle", g), {58'd0, gnt, ack}, 64'd0);
    end
    req = 3'b000;

    // locked core write chain with loader waiting
    do_reset();
    set_op(0, 1'b1, 2'b11, 16'h0100, 64'h1122334455667788);
    set_op(1, 1'b0, 2'b00, 16'h0200, 64'd0);
    req  = 3'b011;
    lock = 3'b001;
    step();
    chk("lk1_gnt",   {61'd0, gnt}, 64'd1);
    chk("lk1_we",    {63'd0, ram_we}, 64'd1);
    chk("lk1_addr",  {48'd0, ram_addr}, 64'h0100);
    chk("lk1_wdata", ram_wdata, 64'h1122334455667788);
    chk("lk1_size",  {62'd0, ram_size}, 64'd3);
    step();
    chk("lk1_ack", {61'd0, ack}, 64'd1);
    chk("lk1_we_wait", {63'd0, ram_we}, 64'd0);
    set_op(0, 1'b1, 2'b11, 16'h0101, 64'hA5A5A5A5_00000002);
    step();
    chk("lk2_hold_gnt", {61'd0, gnt}, 64'd1);
    chk("lk2_hold_ack", {61'd0, ack}, 64'd0);
    step();
    chk("lk2_addr", {48'd0, ram_addr}, 64'h0101);
    chk("lk2_we",   {63'd0, ram_we}, 64'd1);
    step();
    chk("lk2_ack", {61'd0, ack}, 64'd1);
    set_op(0, 1'b1, 2'b11, 16'h0102, 64'hA5A5A5A5_00000003);
    step();
    chk("lk3_hold_gnt", {61'd0, gnt}, 64'd1);
    step();
    chk("lk3_addr", {48'd0, ram_addr}, 64'h0102);
    lock = 3'b000;
    step();
    chk("lk3_ack", {61'd0, ack}, 64'd1);
    req = 3'b010;
    step();
    chk("lk_rel_gnt", {61'd0, gnt}, 64'd0);
    step();
    chk("lk_ld_gnt",  {61'd0, gnt}, 64'd2);
    chk("lk_ld_addr", {48'd0, ram_addr}, 64'h0200);
    chk("lk_ld_we",   {63'd0, ram_we}, 64'd0);
    step();
    chk("lk_ld_ack", {61'd0, ack}, 64'd2);
    req = 3'b000;
    step();
    chk("lk_mem0", mem[10'h100], 64'h1122334455667788);
    chk("lk_mem1", mem[10'h101], 64'hA5A5A5A5_00000002);
    chk("lk_mem2", mem[10'h102], 64'hA5A5A5A5_00000003);

    // lock held forever: forced release after LOCK_MAX accesses
    do_reset();
    set_op(0, 1'b0, 2'b00, 16'h0010, 64'd0);
    set_op(1, 1'b0, 2'b00, 16'h0020, 64'd0);
    req  = 3'b011;
    lock = 3'b001;
    for (int a = 1; a <= 8; a++) begin
      step();
      chk($sformatf("fr%0d_gnt", a), {61'd0, gnt}, 64'd1);
      step();
      chk($sformatf("fr%0d_ack", a), {61'd0, ack}, 64'd1);
      if (a < 8) begin
        step();
        chk($sformatf("fr%0d_hold", a), {61'd0, gnt}, 64'd1);
      end
    end
    step();
    chk("fr_idle_gnt", {61'd0, gnt}, 64'd0);
    step();
    chk("fr_ld_gnt", {61'd0, gnt}, 64'd2);
    step();
    chk("fr_ld_ack", {61'd0, ack}, 64'd2);
    req  = 3'b000;
    lock = 3'b000;
    step();

    // write with size none: no strobe, ack still pulses
    set_op(2, 1'b1, 2'b00, 16'h0300, 64'hCAFEF00D_CAFEF00D);
    req = 3'b100;
    step();
    chk("sz0_gnt",  {61'd0, gnt}, 64'd4);
    chk("sz0_we",   {63'd0, ram_we}, 64'd0);
    chk("sz0_size", {62'd0, ram_size}, 64'd0);
    step();
    chk("sz0_ack", {61'd0, ack}, 64'd4);
    req = 3'b000;
    step();
    chk("sz0_mem", mem[10'h300], 64'd0);

    // reset asserted during ISSUE of a write
    set_op(0, 1'b1, 2'b10, 16'h0400, 64'h0BADBEEF_0BADBEEF);
    req = 3'b001;
    step();
    chk("mr_issue_we", {63'd0, ram_we}, 64'd1);
    rst = 1'b1;
    req = 3'b000;
    #1;
    chk("mr_we",   {63'd0, ram_we}, 64'd0);
    chk("mr_gnt",  {61'd0, gnt}, 64'd0);
    chk("mr_addr", {48'd0, ram_addr}, 64'd0);
    step();
    chk("mr_ack", {61'd0, ack}, 64'd0);
    rst = 1'b0;
    chk("mr_mem", mem[10'h400], 64'd0);
    set_op(1, 1'b0, 2'b00, 16'h0010, 64'd0);
    req = 3'b010;
    step();
    chk("mr_ld_gnt", {61'd0, gnt}, 64'd2);
    step();
    chk("mr_ld_ack",   {61'd0, ack}, 64'd2);
    chk("mr_ld_rdata", rdata, 64'hDEADBEEF_00000001);
    req = 3'b000;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
